alu_issue_ctrl: RTL and testbench

Sequential initiator for the datapath ALU. It accepts operation requests over a valid/ready handshake and decodes each into a 3-bit ALU opcode. It drives registered operands into the ALU, waits a programmable settle time, then captures the result and Zero flag. A single-entry result is returned over a second valid/ready handshake, and branch-compare and set-less-than results are derived from the ALU outputs. It sits between the instruction decode stage and the ALU.

---
 rtl/alu_issue_ctrl.sv | 179 +++++++++++++++++
 tb/tb_alu_issue_ctrl.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: sequential initiator for the datapath ALU.
// Accepts one request at a time, decodes it to an ALU opcode, drives registered
// operands, waits LAT cycles for the ALU to settle, then returns a single
// registered response (data, flag, err) over a valid/ready handshake.
//
// Ports:
//   clk, rst_n                     clock, async active-low reset
//   req_valid/req_ready            request handshake (req_ready registered)
//   req_op, req_a, req_b           operation code and operands
//   alu_op, alu_a, alu_b           registered opcode/operands to the ALU
//   alu_result, alu_zero           ALU outputs, sampled at capture
//   rsp_valid/rsp_ready            response handshake (rsp_valid registered)
//   rsp_data, rsp_flag, rsp_err    response payload
module alu_issue_ctrl #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned LAT   = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [3:0]       req_op,
    input  logic [WIDTH-1:0] req_a,
    input  logic [WIDTH-1:0] req_b,
    output logic [2:0]       alu_op,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_zero,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_data,
    output logic             rsp_flag,
    output logic             rsp_err
);

    localparam int unsigned CNT_W = 4;

    localparam logic [3:0] OP_BNE = 4'd6;
    localparam logic [3:0] OP_SLT = 4'd7;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } stateE;

    stateE            state,      stateNext;
    logic [3:0]       opQ,        opNext;
    logic [2:0]       aluOpQ,     aluOpNext;
    logic [WIDTH-1:0] aluAQ,      aluANext;
    logic [WIDTH-1:0] aluBQ,      aluBNext;
    logic [CNT_W-1:0] cntQ,       cntNext;
    logic             reqReadyQ,  reqReadyNext;
    logic             rspValidQ,  rspValidNext;
    logic [WIDTH-1:0] rspDataQ,   rspDataNext;
    logic             rspFlagQ,   rspFlagNext;
    logic             rspErrQ,    rspErrNext;

    logic             sltFlag;

    // Request opcode to ALU opcode; branches and SLT all use subtract.
    function automatic logic [2:0] decodeOp(input logic [3:0] op);
        case (op)
            4'd0:    decodeOp = 3'b000;
            4'd1:    decodeOp = 3'b001;
            4'd2:    decodeOp = 3'b010;
            4'd3:    decodeOp = 3'b011;
            4'd4:    decodeOp = 3'b100;
            default: decodeOp = 3'b001;
        endcase
    endfunction

    // Signed less-than from the latched operands and a - b; opposite signs
    // decide directly from A's sign so subtract overflow cannot mislead.
    assign sltFlag = (aluAQ[WIDTH-1] != aluBQ[WIDTH-1]) ? aluAQ[WIDTH-1]
                                                        : alu_result[WIDTH-1];

    // State register and all registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            opQ       <= 4'd0;
            aluOpQ    <= 3'b000;
            aluAQ     <= '0;
            aluBQ     <= '0;
            cntQ      <= '0;
            reqReadyQ <= 1'b1;
            rspValidQ <= 1'b0;
            rspDataQ  <= '0;
            rspFlagQ  <= 1'b0;
            rspErrQ   <= 1'b0;
        end else begin
            state     <= stateNext;
            opQ       <= opNext;
            aluOpQ    <= aluOpNext;
            aluAQ     <= aluANext;
            aluBQ     <= aluBNext;
            cntQ      <= cntNext;
            reqReadyQ <= reqReadyNext;
            rspValidQ <= rspValidNext;
            rspDataQ  <= rspDataNext;
            rspFlagQ  <= rspFlagNext;
            rspErrQ   <= rspErrNext;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        stateNext   = state;
        opNext      = opQ;
        aluOpNext   = aluOpQ;
        aluANext    = aluAQ;
        aluBNext    = aluBQ;
        cntNext     = cntQ;
        rspDataNext = rspDataQ;
        rspFlagNext = rspFlagQ;
        rspErrNext  = rspErrQ;

        case (state)
            IDLE: begin
                if (req_valid && reqReadyQ) begin
                    opNext = req_op;
                    if (!req_op[3]) begin
                        aluOpNext = decodeOp(req_op);
                        aluANext  = req_a;
                        aluBNext  = req_b;
                        cntNext   = CNT_W'(LAT);
                        stateNext = EXEC;
                    end else begin
                        // Illegal op: ALU operands stay untouched.
                        rspDataNext = '0;
                        rspFlagNext = 1'b0;
                        rspErrNext  = 1'b1;
                        stateNext   = RESP;
                    end
                end
            end
            EXEC: begin
                if (cntQ <= CNT_W'(1)) begin
                    cntNext    = '0;
                    rspErrNext = 1'b0;
                    if (opQ == OP_SLT) begin
                        rspFlagNext = sltFlag;
                        rspDataNext = WIDTH'(sltFlag);
                    end else if (opQ == OP_BNE) begin
                        rspFlagNext = !alu_zero;
                        rspDataNext = alu_result;
                    end else begin
                        rspFlagNext = alu_zero;
                        rspDataNext = alu_result;
                    end
                    stateNext = RESP;
                end else begin
                    cntNext = cntQ - CNT_W'(1);
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    stateNext = IDLE;
                end
            end
            default: stateNext = IDLE;
        endcase

        reqReadyNext = (stateNext == IDLE);
        rspValidNext = (stateNext == RESP);
    end

    assign req_ready = reqReadyQ;
    assign alu_op    = aluOpQ;
    assign alu_a     = aluAQ;
    assign alu_b     = aluBQ;
    assign rsp_valid = rspValidQ;
    assign rsp_data  = rspDataQ;
    assign rsp_flag  = rspFlagQ;
    assign rsp_err   = rspErrQ;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Testbench for alu_issue_ctrl: two instances (LAT=1 and LAT=3), each paired
// with a behavioural ALU, exercised with directed vectors.
module tb_alu_issue_ctrl;

    localparam int unsigned W = 64;

    logic         clk;
    logic         rstN      [2];
    logic         reqValid  [2];
    logic         reqReady  [2];
    logic [3:0]   reqOp     [2];
    logic [W-1:0] reqA      [2];
    logic [W-1:0] reqB      [2];
    logic [2:0]   aluOp     [2];
    logic [W-1:0] aluA      [2];
    logic [W-1:0] aluB      [2];
    logic [W-1:0] aluResult [2];
    logic         aluZero   [2];
    logic         rspValid  [2];
    logic         rspReady  [2];
    logic [W-1:0] rspData   [2];
    logic         rspFlag   [2];
    logic         rspErr    [2];

    int total = 0;
    int bad   = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [W-1:0] aluModel(input logic [2:0] op,
                                              input logic [W-1:0] a,
                                              input logic [W-1:0] b);
        case (op)
            3'b000:  aluModel = a + b;
            3'b001:  aluModel = a - b;
            3'b010:  aluModel = a & b;
            3'b011:  aluModel = a | b;
            3'b100:  aluModel = b;
            default: aluModel = '0;
        endcase
    endfunction

    for (genvar g = 0; g < 2; g++) begin : gDut
        alu_issue_ctrl #(.WIDTH(W), .LAT(g == 0 ? 1 : 3)) dut (
            .clk        (clk),
            .rst_n      (rstN[g]),
            .req_valid  (reqValid[g]),
            .req_ready  (reqReady[g]),
            .req_op     (reqOp[g]),
            .req_a      (reqA[g]),
            .req_b      (reqB[g]),
            .alu_op     (aluOp[g]),
            .alu_a      (aluA[g]),
            .alu_b      (aluB[g]),
            .alu_result (aluResult[g]),
            .alu_zero   (aluZero[g]),
            .rsp_valid  (rspValid[g]),
            .rsp_ready  (rspReady[g]),
            .rsp_data   (rspData[g]),
            .rsp_flag   (rspFlag[g]),
            .rsp_err    (rspErr[g])
        );
        assign aluResult[g] = aluModel(aluOp[g], aluA[g], aluB[g]);
        assign aluZero[g]   = (aluResult[g] == '0);
    end

    task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full transaction with the response held back until it is checked.
    task automatic runOp(input int idx, input string tag, input logic [3:0] op,
                         input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [2:0] expAluOp, input logic [W-1:0] expAluA,
                         input logic [W-1:0] expAluB, input logic [W-1:0] expData,
                         input logic expFlag, input logic expErr, input int expLat);
        int n;
        reqOp[idx]    = op;
        reqA[idx]     = a;
        reqB[idx]     = b;
        reqValid[idx] = 1'b1;
        tick();
        reqValid[idx] = 1'b0;
        chk({tag, ".aluOp"}, W'(aluOp[idx]), W'(expAluOp));
        chk({tag, ".aluA"}, aluA[idx], expAluA);
        chk({tag, ".aluB"}, aluB[idx], expAluB);
        chk({tag, ".reqReadyBusy"}, W'(reqReady[idx]), W'(1'b0));
        n = 0;
        while (!rspValid[idx] && n < 20) begin
            tick();
            n++;
        end
        chk({tag, ".latency"}, W'(n), W'(expLat));
        chk({tag, ".data"}, rspData[idx], expData);
        chk({tag, ".flag"}, W'(rspFlag[idx]), W'(expFlag));
        chk({tag, ".err"}, W'(rspErr[idx]), W'(expErr));
        rspReady[idx] = 1'b1;
        tick();
        rspReady[idx] = 1'b0;
        chk({tag, ".rspValidDrop"}, W'(rspValid[idx]), W'(1'b0));
        chk({tag, ".reqReadyBack"}, W'(reqReady[idx]), W'(1'b1));
    endtask

    localparam logic [W-1:0] MSB  = 64'h8000_0000_0000_0000;
    localparam logic [W-1:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

    initial begin
        int n;
        logic seen;
        for (int i = 0; i < 2; i++) begin
            rstN[i]     = 1'b0;
            reqValid[i] = 1'b0;
            reqOp[i]    = 4'd0;
            reqA[i]     = '0;
            reqB[i]     = '0;
            rspReady[i] = 1'b0;
        end
        repeat (3) tick();
        chk("rst.reqReady", W'(reqReady[0]), W'(1'b1));
        chk("rst.rspValid", W'(rspValid[0]), W'(1'b0));
        chk("rst.rspData", rspData[0], '0);
        chk("rst.rspFlagErr", W'({rspFlag[0], rspErr[0]}), W'(2'b00));
        chk("rst.alu", W'({aluOp[0], aluA[0][7:0], aluB[0][7:0]}), '0);
        rstN[0] = 1'b1;
        rstN[1] = 1'b1;
        tick();

        // LAT=1 instance: functional vectors.
        runOp(0, "add",   4'd0, 64'd5, 64'd7, 3'b000, 64'd5, 64'd7, 64'd12, 1'b0, 1'b0, 1);
        runOp(0, "beq",   4'd5, 64'h1234, 64'h1234, 3'b001, 64'h1234, 64'h1234, 64'd0, 1'b1, 1'b0, 1);
        runOp(0, "bneEq", 4'd6, 64'h1234, 64'h1234, 3'b001, 64'h1234, 64'h1234, 64'd0, 1'b0, 1'b0, 1);
        runOp(0, "bneNe", 4'd6, 64'd1, 64'd2, 3'b001, 64'd1, 64'd2, ONES, 1'b1, 1'b0, 1);
        runOp(0, "sltNeg", 4'd7, MSB, 64'd1, 3'b001, MSB, 64'd1, 64'd1, 1'b1, 1'b0, 1);
        runOp(0, "sltPos", 4'd7, 64'd1, MSB, 3'b001, 64'd1, MSB, 64'd0, 1'b0, 1'b0, 1);
        runOp(0, "illegal", 4'd9, 64'hDEAD, 64'hBEEF, 3'b001, 64'd1, MSB, 64'd0, 1'b0, 1'b1, 0);
        runOp(0, "addWrap", 4'd0, ONES, 64'd1, 3'b000, ONES, 64'd1, 64'd0, 1'b1, 1'b0, 1);
        runOp(0, "and",   4'd2, 64'hF0F0, 64'hFF00, 3'b010, 64'hF0F0, 64'hFF00, 64'hF000, 1'b0, 1'b0, 1);
        runOp(0, "passb", 4'd4, 64'd3, 64'd0, 3'b100, 64'd3, 64'd0, 64'd0, 1'b1, 1'b0, 1);
        runOp(0, "sub",   4'd1, 64'd10, 64'd3, 3'b001, 64'd10, 64'd3, 64'd7, 1'b0, 1'b0, 1);

        // LAT=3 instance: backpressure with request held throughout.
        reqOp[1]    = 4'd3;
        reqA[1]     = 64'hF0;
        reqB[1]     = 64'h0F;
        reqValid[1] = 1'b1;
        tick();
        chk("bp.aluOp", W'(aluOp[1]), W'(3'b011));
        n = 0;
        while (!rspValid[1] && n < 20) begin
            chk("bp.reqReadyExec", W'(reqReady[1]), W'(1'b0));
            tick();
            n++;
        end
        chk("bp.latency", W'(n), W'(3));
        for (int i = 0; i < 5; i++) begin
            chk("bp.rspValidHeld", W'(rspValid[1]), W'(1'b1));
            chk("bp.dataHeld", rspData[1], 64'hFF);
            chk("bp.reqReadyResp", W'(reqReady[1]), W'(1'b0));
            tick();
        end
        rspReady[1] = 1'b1;
        tick();
        chk("bp.done.rspValid", W'(rspValid[1]), W'(1'b0));
        chk("bp.done.reqReady", W'(reqReady[1]), W'(1'b1));
        tick();
        reqValid[1] = 1'b0;
        chk("bp.heldAccepted", W'(reqReady[1]), W'(1'b0));
        n = 0;
        while (!rspValid[1] && n < 20) begin
            tick();
            n++;
        end
        chk("bp2.latency", W'(n), W'(3));
        chk("bp2.data", rspData[1], 64'hFF);
        tick();
        chk("bp2.consumedFirst", W'(rspValid[1]), W'(1'b0));
        rspReady[1] = 1'b0;

        // LAT=3 instance: reset in the middle of a SUB.
        reqOp[1]    = 4'd1;
        reqA[1]     = 64'd10;
        reqB[1]     = 64'd3;
        reqValid[1] = 1'b1;
        tick();
        reqValid[1] = 1'b0;
        chk("rstMid.aluA", aluA[1], 64'd10);
        #2;
        rstN[1] = 1'b0;
        #1;
        chk("rstMid.aluOp", W'(aluOp[1]), W'(3'b000));
        chk("rstMid.aluA0", aluA[1], '0);
        chk("rstMid.aluB0", aluB[1], '0);
        chk("rstMid.reqReady", W'(reqReady[1]), W'(1'b1));
        chk("rstMid.rspValid", W'(rspValid[1]), W'(1'b0));
        tick();
        rstN[1] = 1'b1;
        seen = 1'b0;
        repeat (6) begin
            tick();
            seen = seen | rspValid[1];
        end
        chk("rstMid.noRsp", W'(seen), W'(1'b0));
        chk("rstMid.reqReadyAfter", W'(reqReady[1]), W'(1'b1));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
